branch_cond_unit: RTL and testbench

Parametrised branch-condition unit for the bus-based CPU datapath. It evaluates one of 16 condition codes from the instruction register against a value on the shared bus. The first six codes keep the single-operand zero/sign tests. The remaining codes are two-operand signed/unsigned compares against a previously latched operand A. Evaluation runs through a 3-state FSM with a busy/valid handshake, and a saturating counter records taken conditions.

---
 rtl/branch_cond_unit.sv | 127 ++++++++++++
 tb/tb_branch_cond_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_cond_unit.sv
// Branch-condition unit: evaluates a 4-bit condition code against the bus, either
// as a single-operand test or as a signed/unsigned compare with latched operand A.
module branch_cond_unit #(
  parameter int W      = 32,
  parameter int CC_LSB = 0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     bus,
  input  logic [W-1:0]     ir,
  input  logic             ld_a,
  input  logic             con_in,
  output logic             con_out,
  output logic             cond_valid,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, RES} state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     a_reg, a_snap_reg, b_reg;
  logic [3:0]       cc_reg;
  logic             z_reg, n_reg, c_reg, v_reg, bz_reg, bs_reg;
  logic             con_out_reg, cond_valid_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [W:0]       diff;
  logic             start, load_a, cond;
  logic             unused_ir;

  // Only the condition field of ir is consumed.
  assign unused_ir = ^ir;

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (con_in) begin
          start      = 1'b1;
          state_next = EVAL;
        end
      end
      EVAL:    state_next = RES;
      RES:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign load_a = (state_reg == IDLE) && ld_a && !con_in;
  assign diff   = {1'b0, a_snap_reg} - {1'b0, b_reg};

  // n^v is the signed less-than; c is the unsigned borrow.
  always_comb begin
    cond = 1'b0;
    case (cc_reg)
      4'd0:    cond = 1'b0;
      4'd1:    cond = 1'b1;
      4'd2:    cond = bz_reg;
      4'd3:    cond = !bz_reg;
      4'd4:    cond = !bs_reg;
      4'd5:    cond = bs_reg;
      4'd6:    cond = z_reg;
      4'd7:    cond = !z_reg;
      4'd8:    cond = n_reg ^ v_reg;
      4'd9:    cond = !(n_reg ^ v_reg);
      4'd10:   cond = c_reg;
      4'd11:   cond = !c_reg;
      4'd12:   cond = !z_reg && !(n_reg ^ v_reg);
      4'd13:   cond = z_reg || (n_reg ^ v_reg);
      4'd14:   cond = !z_reg && !c_reg;
      4'd15:   cond = z_reg || c_reg;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      a_reg          <= '0;
      a_snap_reg     <= '0;
      b_reg          <= '0;
      cc_reg         <= '0;
      z_reg          <= 1'b0;
      n_reg          <= 1'b0;
      c_reg          <= 1'b0;
      v_reg          <= 1'b0;
      bz_reg         <= 1'b0;
      bs_reg         <= 1'b0;
      con_out_reg    <= 1'b0;
      cond_valid_reg <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      cond_valid_reg <= (state_reg == RES);
      if (load_a) begin
        a_reg <= bus;
      end
      if (start) begin
        b_reg      <= bus;
        cc_reg     <= ir[CC_LSB +: 4];
        a_snap_reg <= a_reg;
      end
      if (state_reg == EVAL) begin
        z_reg  <= (diff[W-1:0] == '0);
        n_reg  <= diff[W-1];
        c_reg  <= diff[W];
        v_reg  <= (a_snap_reg[W-1] != b_reg[W-1]) && (diff[W-1] != a_snap_reg[W-1]);
        bz_reg <= (b_reg == '0);
        bs_reg <= b_reg[W-1];
      end
      if (state_reg == RES) begin
        con_out_reg <= cond;
        if (cond && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign busy       = (state_reg == EVAL) || (state_reg == RES);
  assign con_out    = con_out_reg;
  assign cond_valid = cond_valid_reg;
  assign taken_cnt  = cnt_reg;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Scoreboard bench for branch_cond_unit: stimulus pushes expected resolutions from a
// compare-level reference model; a negedge monitor pops and checks them.
module tb_branch_cond_unit;
  localparam int W      = 32;
  localparam int CC_LSB = 8;
  localparam int CNT_W  = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ld_a = 1'b0;
  logic             con_in = 1'b0;
  logic [W-1:0]     bus = '0;
  logic [W-1:0]     ir = '0;
  logic             con_out, cond_valid, busy;
  logic [CNT_W-1:0] taken_cnt;

  always #5 clk = ~clk;

  branch_cond_unit #(.W(W), .CC_LSB(CC_LSB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ir(ir), .ld_a(ld_a), .con_in(con_in),
    .con_out(con_out), .cond_valid(cond_valid), .busy(busy), .taken_cnt(taken_cnt)
  );

  typedef struct {
    logic       con;
    int         cnt;
    int         cc;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_a = '0;
  int           m_cnt = 0;
  int           m_busy = 0;
  logic         exp_valid = 1'b0;
  logic         exp_hold = 1'b0;
  int           exp_cnt_vis = 0;
  logic         mon_en = 1'b0;

  function automatic logic ref_cond(input int cc, input logic [W-1:0] a, input logic [W-1:0] b);
    case (cc)
      0:  return 1'b0;
      1:  return 1'b1;
      2:  return b == 0;
      3:  return b != 0;
      4:  return !b[W-1];
      5:  return b[W-1];
      6:  return a == b;
      7:  return a != b;
      8:  return $signed(a) <  $signed(b);
      9:  return $signed(a) >= $signed(b);
      10: return a <  b;
      11: return a >= b;
      12: return $signed(a) >  $signed(b);
      13: return $signed(a) <= $signed(b);
      14: return a >  b;
      default: return a <= b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference behaviour applied at each rising edge, from the inputs just sampled.
  task automatic model_edge();
    exp_t e;
    exp_valid = (!rst && m_busy == 1);
    if (rst) begin
      m_a = '0; m_cnt = 0; m_busy = 0; q.delete();
      exp_hold = 1'b0; exp_cnt_vis = 0;
    end else if (m_busy == 0 && con_in) begin
      e.cc  = int'(ir[CC_LSB +: 4]);
      e.a   = m_a;
      e.b   = bus;
      e.con = ref_cond(e.cc, m_a, bus);
      if (e.con && m_cnt < CMAX) m_cnt++;
      e.cnt = m_cnt;
      q.push_back(e);
      m_busy = 2;
    end else begin
      if (m_busy == 0 && ld_a) m_a = bus;
      if (m_busy > 0) m_busy--;
    end
  endtask

  task automatic cyc(input logic r, input logic la, input logic ci,
                     input logic [W-1:0] b, input int cc);
    logic [W-1:0] t;
    t = $urandom;
    t[CC_LSB +: 4] = 4'(cc);
    rst = r; ld_a = la; con_in = ci; bus = b; ir = t;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Load A, start with B, then two busy cycles that disturb bus and ld_a.
  task automatic eval(input logic [W-1:0] a, input logic [W-1:0] b, input int cc);
    cyc(0, 1, 0, a, 0);
    cyc(0, 0, 1, b, cc);
    cyc(0, 1, 0, $urandom, $urandom_range(15));
    cyc(0, 1, 0, $urandom, $urandom_range(15));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("busy", W'(busy), W'(m_busy > 0));
      chk("cond_valid", W'(cond_valid), W'(exp_valid));
      if (cond_valid && exp_valid && q.size() > 0) begin
        e = q.pop_front();
        $display("txn cc=%0d a=%08h b=%08h con_out=%0d taken_cnt=%0d", e.cc, e.a, e.b, con_out, taken_cnt);
        chk("con_out", W'(con_out), W'(e.con));
        chk("taken_cnt", W'(taken_cnt), W'(e.cnt));
        exp_hold    = e.con;
        exp_cnt_vis = e.cnt;
      end else if (!cond_valid) begin
        chk("con_out_hold", W'(con_out), W'(exp_hold));
        chk("taken_cnt_hold", W'(taken_cnt), W'(exp_cnt_vis));
      end
    end
  end

  initial begin
    logic [W-1:0] vals[5];
    logic [W-1:0] b;
    vals[0] = 32'h0; vals[1] = 32'h1; vals[2] = 32'h7FFF_FFFF;
    vals[3] = 32'h8000_0000; vals[4] = 32'hFFFF_FFFF;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    mon_en = 1'b1;
    cyc(0, 0, 0, 0, 0);

    // Single-operand codes, with arbitrary A loaded first
    eval($urandom, 32'h0, 2);
    eval($urandom, 32'h8000_0000, 5);
    eval($urandom, $urandom, 0);
    eval($urandom, $urandom, 1);
    eval($urandom, 32'h5, 3);
    eval($urandom, 32'h5, 4);

    // Signed vs unsigned compares
    eval(32'hFFFF_FFFF, 32'h1, 8);
    eval(32'hFFFF_FFFF, 32'h1, 10);
    eval(32'hFFFF_FFFF, 32'h1, 14);
    eval(32'hFFFF_FFFF, 32'h1, 13);

    // Overflow path and equality
    eval(32'h7FFF_FFFF, 32'h8000_0000, 12);
    eval(32'h1234_5678, 32'h1234_5678, 6);
    eval(32'h1234_5678, 32'h1234_5678, 15);
    eval(32'h1234_5678, 32'h1234_5678, 12);

    // ld_a together with con_in must not change A
    cyc(0, 1, 0, 32'h10, 0);
    cyc(0, 1, 1, 32'h20, 6);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h10, 6);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // con_in held for 6 cycles: two evaluations
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, $urandom, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);

    // Reset while in RES, then a fresh evaluation
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    eval(32'h3, 32'h3, 6);
    cyc(0, 0, 0, 0, 0);

    // Counter saturation
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) eval($urandom, $urandom, 1);
    for (int i = 0; i < 2; i++) eval($urandom, $urandom, 0);
    cyc(1, 0, 0, 0, 0);

    // Random traffic with operand values biased toward boundaries and equality
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3))
        0: b = vals[$urandom_range(4)];
        1: b = m_a;
        default: b = $urandom;
      endcase
      cyc(($urandom_range(79) == 0), ($urandom_range(2) == 0), ($urandom_range(1) == 0),
          b, $urandom_range(15));
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);

    chk("pending_at_end", W'(q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
